// File: rtl/pc_fetch_controller_pkg.sv
// Shared types and constants for the instruction fetch front end.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DELIVER = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0064;
  localparam int unsigned INST_BYTES       = 4;

endpackage

// File: rtl/pc_fetch_controller.sv
// Fetch PC sequencer: issues held imem reads, buffers the returned
// instruction for decode, and applies redirects with in-flight squash.
module pc_fetch_controller
  import pc_fetch_pkg::*;
#(
  parameter int unsigned       WIDTH      = 32,
  parameter logic [WIDTH-1:0]  RESET_PC   = WIDTH'(pc_fetch_pkg::RESET_PC_DEFAULT),
  parameter int unsigned       INST_BYTES = pc_fetch_pkg::INST_BYTES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             stall,
  input  logic             imem_resp,
  input  logic [31:0]      imem_rdata,
  output logic             imem_read,
  output logic [WIDTH-1:0] imem_address,
  output logic             inst_valid,
  output logic [31:0]      inst,
  output logic [WIDTH-1:0] inst_pc,
  output logic [WIDTH-1:0] pc
);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic             squash_q, squash_d;
  logic             read_q, read_d;
  logic             valid_q, valid_d;
  logic [31:0]      inst_q, inst_d;
  logic [WIDTH-1:0] inst_pc_q, inst_pc_d;
  logic [WIDTH-1:0] target_aligned;

  assign target_aligned = {redirect_target[WIDTH-1:2], 2'b00};

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    squash_d      = squash_q;
    read_d        = read_q;
    valid_d       = valid_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;

    case (state_q)
      IDLE: begin
        if (redirect_valid) pc_d = target_aligned;
        state_d = REQ;
        read_d  = 1'b1;
      end

      REQ: begin
        // An issued read cannot be withdrawn, so a redirect without a
        // response only parks the target until the stale data returns.
        if (redirect_valid) begin
          if (imem_resp) begin
            pc_d     = target_aligned;
            squash_d = 1'b0;
          end else begin
            squash_d      = 1'b1;
            pend_target_d = target_aligned;
          end
        end else if (imem_resp) begin
          if (squash_q) begin
            pc_d     = pend_target_q;
            squash_d = 1'b0;
          end else begin
            inst_d    = imem_rdata;
            inst_pc_d = pc_q;
            valid_d   = 1'b1;
            read_d    = 1'b0;
            state_d   = DELIVER;
          end
        end
      end

      DELIVER: begin
        if (redirect_valid || !stall) begin
          pc_d    = redirect_valid ? target_aligned : pc_q + WIDTH'(INST_BYTES);
          valid_d = 1'b0;
          read_d  = 1'b1;
          state_d = REQ;
        end
      end

      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      pend_target_q <= '0;
      squash_q      <= 1'b0;
      read_q        <= 1'b0;
      valid_q       <= 1'b0;
      inst_q        <= '0;
      inst_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      squash_q      <= squash_d;
      read_q        <= read_d;
      valid_q       <= valid_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
    end
  end

  assign imem_read    = read_q;
  assign imem_address = pc_q;
  assign inst_valid   = valid_q;
  assign inst         = inst_q;
  assign inst_pc      = inst_pc_q;
  assign pc           = pc_q;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Self-checking bench for pc_fetch_controller: directed vector table,
// reset/wrap sequence, then randomized traffic against a delivery-order model.
module tb_pc_fetch_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        stall = 1'b0;
  logic        imem_resp = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_fetch_controller #(.WIDTH(32), .RESET_PC(32'h0000_0064), .INST_BYTES(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall           (stall),
    .imem_resp       (imem_resp),
    .imem_rdata      (imem_rdata),
    .imem_read       (imem_read),
    .imem_address    (imem_address),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .pc              (pc)
  );

  typedef struct {
    logic        rv;
    logic [31:0] tgt;
    logic        st;
    logic        rsp;
    logic [31:0] rd;
    logic        e_read;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic [31:0] e_inst;
  } row_t;

  row_t rows[23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F11;
  endfunction

  task automatic check_outputs(input string tag, input logic e_read, input logic [31:0] e_addr,
                               input logic e_iv, input logic [31:0] e_ipc, input logic [31:0] e_inst);
    chk({tag, " imem_read"},  {31'b0, imem_read},  {31'b0, e_read});
    chk({tag, " pc"},         pc,                  e_addr);
    if (e_read) chk({tag, " imem_address"}, imem_address, e_addr);
    chk({tag, " inst_valid"}, {31'b0, inst_valid}, {31'b0, e_iv});
    chk({tag, " inst_pc"},    inst_pc,             e_ipc);
    chk({tag, " inst"},       inst,                e_inst);
  endtask

  task automatic drive_idle();
    redirect_valid  = 1'b0;
    redirect_target = '0;
    stall           = 1'b0;
    imem_resp       = 1'b0;
    imem_rdata      = '0;
  endtask

  // random-phase model state
  logic [31:0] exp_pc, p_addr, p_ipc, p_inst, tgt;
  logic        p_read, p_resp, p_iv, rv, st, rsp;
  logic [31:0] rd;
  int          cnt, lat, idle, ndlv;

  initial begin
    //           rv  tgt           st  rsp rd            rd  addr          iv  ipc           inst
    rows[0]  = '{0, 32'h0,        0, 0, 32'h0,         1, 32'h64,        0, 32'h0,        32'h0};
    rows[1]  = '{0, 32'h0,        0, 0, 32'h0,         1, 32'h64,        0, 32'h0,        32'h0};
    rows[2]  = '{0, 32'h0,        0, 1, 32'hA0A0_0000, 0, 32'h64,        1, 32'h64,       32'hA0A0_0000};
    rows[3]  = '{0, 32'h0,        0, 0, 32'h0,         1, 32'h68,        0, 32'h64,       32'hA0A0_0000};
    rows[4]  = '{0, 32'h0,        0, 0, 32'h0,         1, 32'h68,        0, 32'h64,       32'hA0A0_0000};
    rows[5]  = '{0, 32'h0,        0, 1, 32'hA1A1_0001, 0, 32'h68,        1, 32'h68,       32'hA1A1_0001};
    rows[6]  = '{0, 32'h0,        1, 1, 32'hBAD0_0001, 0, 32'h68,        1, 32'h68,       32'hA1A1_0001};
    rows[7]  = '{0, 32'h0,        1, 0, 32'h0,         0, 32'h68,        1, 32'h68,       32'hA1A1_0001};
    rows[8]  = '{0, 32'h0,        1, 0, 32'h0,         0, 32'h68,        1, 32'h68,       32'hA1A1_0001};
    rows[9]  = '{0, 32'h0,        1, 0, 32'h0,         0, 32'h68,        1, 32'h68,       32'hA1A1_0001};
    rows[10] = '{0, 32'h0,        1, 0, 32'h0,         0, 32'h68,        1, 32'h68,       32'hA1A1_0001};
    rows[11] = '{0, 32'h0,        0, 0, 32'h0,         1, 32'h6C,        0, 32'h68,       32'hA1A1_0001};
    rows[12] = '{1, 32'h200,      0, 0, 32'h0,         1, 32'h6C,        0, 32'h68,       32'hA1A1_0001};
    rows[13] = '{0, 32'h0,        0, 0, 32'h0,         1, 32'h6C,        0, 32'h68,       32'hA1A1_0001};
    rows[14] = '{0, 32'h0,        0, 1, 32'hDEAD_BEEF, 1, 32'h200,       0, 32'h68,       32'hA1A1_0001};
    rows[15] = '{0, 32'h0,        0, 1, 32'hA2A2_0002, 0, 32'h200,       1, 32'h200,      32'hA2A2_0002};
    rows[16] = '{0, 32'h0,        0, 0, 32'h0,         1, 32'h204,       0, 32'h200,      32'hA2A2_0002};
    rows[17] = '{1, 32'h103,      0, 1, 32'hBAD0_0002, 1, 32'h100,       0, 32'h200,      32'hA2A2_0002};
    rows[18] = '{0, 32'h0,        0, 1, 32'hA3A3_0003, 0, 32'h100,       1, 32'h100,      32'hA3A3_0003};
    rows[19] = '{1, 32'h400,      1, 0, 32'h0,         1, 32'h400,       0, 32'h100,      32'hA3A3_0003};
    rows[20] = '{0, 32'h0,        0, 1, 32'hA4A4_0004, 0, 32'h400,       1, 32'h400,      32'hA4A4_0004};
    rows[21] = '{0, 32'h0,        1, 0, 32'h0,         0, 32'h400,       1, 32'h400,      32'hA4A4_0004};
    rows[22] = '{0, 32'h0,        0, 0, 32'h0,         1, 32'h404,       0, 32'h400,      32'hA4A4_0004};

    drive_idle();
    #12;
    check_outputs("reset", 1'b0, 32'h64, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      redirect_valid  = rows[i].rv;
      redirect_target = rows[i].tgt;
      stall           = rows[i].st;
      imem_resp       = rows[i].rsp;
      imem_rdata      = rows[i].rd;
      @(posedge clk);
      #1;
      check_outputs($sformatf("row%0d", i), rows[i].e_read, rows[i].e_addr,
                    rows[i].e_iv, rows[i].e_ipc, rows[i].e_inst);
    end

    // Reset mid-request, redirect out of IDLE near the top, then wrap.
    #2;
    drive_idle();
    rst = 1'b1;
    #1;
    check_outputs("midreq_reset", 1'b0, 32'h64, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    check_outputs("idle_redirect", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    drive_idle();
    imem_resp  = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    check_outputs("top_deliver", 1'b0, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678);
    @(negedge clk);
    drive_idle();
    @(posedge clk); #1;
    check_outputs("wrap", 1'b1, 32'h0, 1'b0, 32'hFFFF_FFFC, 32'h1234_5678);

    // Randomized traffic: every delivered instruction must be the next one
    // in program order (sequential or last redirect target) with its data.
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    #1;
    check_outputs("rand_reset", 1'b0, 32'h64, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst    = 1'b0;
    exp_pc = 32'h64;
    p_read = 1'b0; p_resp = 1'b0; p_iv = 1'b0;
    p_addr = '0; p_ipc = '0; p_inst = '0;
    cnt = 0; lat = 1; idle = 0; ndlv = 0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("no_overlap", {31'b0, imem_read & inst_valid}, 32'h0);
      if (imem_read && p_read && !p_resp) chk("addr_hold", imem_address, p_addr);
      if (inst_valid && !p_iv) begin
        chk("dlv_pc", inst_pc, exp_pc);
        chk("dlv_inst", inst, memf(inst_pc));
        ndlv++;
      end else if (inst_valid) begin
        chk("hold_pc", inst_pc, p_ipc);
        chk("hold_inst", inst, p_inst);
      end
      if (inst_valid) idle = 0;
      else idle++;
      if (idle > 200) begin
        chk("liveness_cycles", idle, 200);
        break;
      end

      if (imem_read) cnt++;
      else cnt = 0;
      rsp = 1'b0;
      rd  = $urandom;
      if (imem_read && cnt > lat) begin
        rsp = 1'b1;
        rd  = memf(imem_address);
        cnt = 0;
        lat = $urandom_range(1, 4);
      end else if (!imem_read && $urandom_range(0, 9) == 0) begin
        rsp = 1'b1;
      end
      rv  = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      st  = ($urandom_range(0, 2) == 0);

      redirect_valid  = rv;
      redirect_target = tgt;
      stall           = st;
      imem_resp       = rsp;
      imem_rdata      = rd;

      if (rv) exp_pc = tgt & 32'hFFFF_FFFC;
      else if (inst_valid && !st) exp_pc = inst_pc + 32'd4;

      p_read = imem_read;
      p_resp = rsp & imem_read;
      p_addr = imem_address;
      p_iv   = inst_valid;
      p_ipc  = inst_pc;
      p_inst = inst;
    end
    chk("deliveries_seen", {31'b0, ndlv > 100}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
